// File: rtl/systolic_load_seq_if.sv
// Activation stream handshake between the activation source and the loading sequencer.
interface systolic_load_seq_if #(
  parameter int unsigned W = 8
) ();
  logic                a_valid;
  logic signed [W-1:0] a_data;
  logic                a_ready;

  modport master (output a_valid, output a_data, input  a_ready);
  modport slave  (input  a_valid, input  a_data, output a_ready);
endinterface

// File: rtl/systolic_load_seq.sv
// Loading sequencer for the MAC array: streams activations, builds the staggered
// per-MAC valid wavefront, optionally clears accumulators, and signals completion.
module systolic_load_seq #(
  parameter int unsigned N_MACS = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  clear_mode,
  systolic_load_seq_if.slave    a_if,
  output logic signed [W-1:0]   a_out,
  output logic [N_MACS-1:0]     valid_ctrl,
  output logic [N_MACS-1:0]     clear_ctrl,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(N_MACS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] drain_cnt;
  logic             empty_pend;
  logic             hs_c;

  assign hs_c = a_if.a_valid & a_if.a_ready;

  // Next-state decode; an empty pass waits one IDLE cycle so its done pulse lands on edge 1.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (empty_pend) begin
          state_n = DONE;
        end else if (start && (len != '0)) begin
          state_n = clear_mode ? CLEAR : STREAM;
        end
      end
      CLEAR:  state_n = STREAM;
      STREAM: if (hs_c && (remaining == LEN_W'(1))) state_n = DRAIN;
      DRAIN:  if (drain_cnt == '0) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; drain runs until the last lane's valid has gone by.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      drain_cnt    <= '0;
      empty_pend   <= 1'b0;
      a_if.a_ready <= 1'b0;
      a_out        <= '0;
      valid_ctrl   <= '0;
      clear_ctrl   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state      <= state_n;
      empty_pend <= (state == IDLE) && !empty_pend && start && (len == '0);

      if ((state == IDLE) && !empty_pend && start) begin
        remaining <= len;
      end else if (hs_c) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (state == DRAIN) begin
        drain_cnt <= drain_cnt - CNT_W'(1);
      end else begin
        drain_cnt <= CNT_W'(N_MACS - 1);
      end

      if (hs_c) begin
        a_out <= a_if.a_data;
      end

      a_if.a_ready <= (state_n == STREAM);
      valid_ctrl   <= {valid_ctrl[N_MACS-2:0], hs_c};
      clear_ctrl   <= {N_MACS{state_n == CLEAR}};
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_load_seq.sv
// Self-checking bench for systolic_load_seq: vector table, randomized passes and corner sequences
// compared against an event-schedule reference model.
module tb_systolic_load_seq;

  localparam int unsigned N_MACS = 4;
  localparam int unsigned W      = 8;
  localparam int unsigned LEN_W  = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [LEN_W-1:0]     len = '0;
  logic                 clear_mode = 1'b0;
  logic signed [W-1:0]  a_out;
  logic [N_MACS-1:0]    valid_ctrl;
  logic [N_MACS-1:0]    clear_ctrl;
  logic                 busy;
  logic                 done;

  systolic_load_seq_if #(.W(W)) a_if ();

  systolic_load_seq #(.N_MACS(N_MACS), .W(W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .clear_mode (clear_mode),
    .a_if       (a_if),
    .a_out      (a_out),
    .valid_ctrl (valid_ctrl),
    .clear_ctrl (clear_ctrl),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Fixed-stimulus mode for the hand-written sequences
  bit                  use_fixed = 1'b0;
  logic signed [W-1:0] fix_data[$];
  bit                  fix_valid[$];
  logic [N_MACS-1:0]   obs_vc[$];
  int                  obs_done_t;
  logic signed [W-1:0] m_aout = '0;

  typedef struct {
    int len;
    bit clr;
    int stall_pct;
    bit poke;
    int exp_done_t;   // -1 when stalls make it stimulus dependent
  } vec_t;

  task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // One pass: the model tracks accept edges and derives every output from them.
  task automatic run_pass(input int plen, input bit clr, input int stall_pct, input bit poke);
    int base, got, last_e, t, fi;
    int acc_e[$];
    logic [N_MACS-1:0] ev;
    bit er, ec, ed, eb, fin, drv_v;
    logic signed [W-1:0] drv_d;

    obs_vc.delete();
    obs_done_t = -1;
    start = 1'b1;
    len = LEN_W'(plen);
    clear_mode = clr;
    a_if.a_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base = clr ? 1 : 0;
    got = 0; last_e = -1; fi = 0; t = 0; fin = 1'b0;

    while (!fin) begin
      er = (plen != 0) && (t >= base) && (got < plen);
      ec = (plen != 0) && clr && (t == 0);
      ev = '0;
      foreach (acc_e[i])
        for (int j = 0; j < int'(N_MACS); j++)
          if (acc_e[i] + j == t) ev[j] = 1'b1;
      if (plen == 0) begin
        ed = (t == 1);
        eb = (t == 1);
      end else begin
        ed = (got == plen) && (t == last_e + int'(N_MACS));
        eb = (got < plen) || (t <= last_e + int'(N_MACS));
      end

      check("a_ready",    t, 32'(a_if.a_ready), 32'(er));
      check("clear_ctrl", t, 32'(clear_ctrl),   ec ? 32'((1 << N_MACS) - 1) : 32'd0);
      check("valid_ctrl", t, 32'(valid_ctrl),   32'(ev));
      check("done",       t, 32'(done),         32'(ed));
      check("busy",       t, 32'(busy),         32'(eb));
      check("a_out",      t, 32'(a_out),        32'(m_aout));
      obs_vc.push_back(valid_ctrl);
      if (done) obs_done_t = t;

      if ((plen == 0) ? (t >= 2) : ((got == plen) && (t > last_e + int'(N_MACS)))) fin = 1'b1;
      if (!fin && t >= 1000) begin
        check("timeout", t, 32'd1, 32'd0);
        fin = 1'b1;
      end

      if (!fin) begin
        if (use_fixed) begin
          drv_v = (t >= base && (t - base) < fix_valid.size()) ? fix_valid[t - base] : 1'b1;
          drv_d = (fi < fix_data.size()) ? fix_data[fi] : W'($urandom);
        end else begin
          drv_v = ($urandom_range(99) >= stall_pct);
          drv_d = W'($urandom);
        end
        a_if.a_valid = drv_v;
        a_if.a_data  = drv_d;
        start = poke && eb && (ed || ($urandom_range(3) == 0));
        len = LEN_W'($urandom_range(9, 1));
        @(posedge clk);
        if (er && drv_v) begin
          got++;
          acc_e.push_back(t + 1);
          m_aout = drv_d;
          last_e = t + 1;
          fi++;
        end
        #1;
        t++;
      end
    end
    a_if.a_valid = 1'b0;
    start = 1'b0;
  endtask

  vec_t vecs[8];
  logic [N_MACS-1:0] exp_seq[7];

  initial begin
    a_if.a_valid = 1'b0;
    a_if.a_data  = '0;
    #12;
    check("rst_a_ready", 0, 32'(a_if.a_ready), 32'd0);
    check("rst_valid",   0, 32'(valid_ctrl),   32'd0);
    check("rst_clear",   0, 32'(clear_ctrl),   32'd0);
    check("rst_busy",    0, 32'(busy),         32'd0);
    check("rst_done",    0, 32'(done),         32'd0);
    check("rst_a_out",   0, 32'(a_out),        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_aout = '0;

    vecs[0] = '{3,  1'b0, 0,  1'b0, 7};
    vecs[1] = '{1,  1'b0, 0,  1'b0, 5};
    vecs[2] = '{5,  1'b1, 0,  1'b0, 10};
    vecs[3] = '{0,  1'b0, 0,  1'b0, 1};
    vecs[4] = '{8,  1'b0, 30, 1'b1, -1};
    vecs[5] = '{4,  1'b1, 40, 1'b1, -1};
    vecs[6] = '{2,  1'b0, 0,  1'b1, 6};
    vecs[7] = '{12, 1'b1, 20, 1'b0, -1};
    foreach (vecs[i]) begin
      run_pass(vecs[i].len, vecs[i].clr, vecs[i].stall_pct, vecs[i].poke);
      if (vecs[i].exp_done_t >= 0) check("done_cycle", i, 32'(obs_done_t), 32'(vecs[i].exp_done_t));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    for (int p = 0; p < 12; p++)
      run_pass(int'($urandom_range(9)), 1'($urandom_range(1)), int'($urandom_range(50)), 1'($urandom_range(1)));

    // Worked example: 10/20/30 with no stalls
    use_fixed = 1'b1;
    fix_data = '{8'sd10, 8'sd20, 8'sd30};
    fix_valid.delete();
    run_pass(3, 1'b0, 0, 1'b0);
    exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int k = 0; k < 7; k++) check("wavefront_seq", k + 1, 32'(obs_vc[k + 1]), 32'(exp_seq[k]));
    check("wavefront_done", 0, 32'(obs_done_t), 32'd7);

    // One bubble between two elements
    fix_data = '{8'sd5, -8'sd7};
    fix_valid = '{1'b1, 1'b0, 1'b1};
    run_pass(2, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("stall_lane0", k + 1, 32'(obs_vc[k + 1][0]), 32'(k != 1));
      check("stall_lane3", k + 4, 32'(obs_vc[k + 4][3]), 32'(k != 1));
    end
    check("stall_done", 0, 32'(obs_done_t), 32'd7);
    use_fixed = 1'b0;

    // Reset in the middle of a stream
    start = 1'b1; len = LEN_W'(6); clear_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a_if.a_valid = 1'b1; a_if.a_data = 8'sd33;
    repeat (3) @(posedge clk);
    #1;
    check("mid_vc_nonzero", 0, 32'(valid_ctrl != '0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_ready", 0, 32'(a_if.a_ready), 32'd0);
    check("arst_valid",   0, 32'(valid_ctrl),   32'd0);
    check("arst_busy",    0, 32'(busy),         32'd0);
    check("arst_a_out",   0, 32'(a_out),        32'd0);
    a_if.a_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_aout = '0;
    run_pass(3, 1'b0, 0, 1'b0);
    check("post_rst_done", 0, 32'(obs_done_t), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
